// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD test-pattern generator.
// Latency: n/a (declarations only). Backpressure: n/a.
package lcd_pkg;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_BARS  = 2'd2,
        PAT_GRAD  = 2'd3
    } pat_mode_t;

    localparam rgb565_t RGB_BLACK = 16'h0000;
    localparam rgb565_t RGB_WHITE = 16'hFFFF;

    // Bar index bits map straight onto saturated R, G, B channels.
    function automatic rgb565_t bar_color(input logic [2:0] idx);
        return {{5{idx[2]}}, {6{idx[1]}}, {5{idx[0]}}};
    endfunction

endpackage

// File: rtl/lcd_pattern_gen_if.sv
// Pixel-coordinate / colour bundle between the st7735 driver and the pattern generator.
// Latency: n/a (wires only). Backpressure: none, the driver paces pixels.
interface lcd_pattern_gen_if #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int DIV_W = 4
);
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [1:0]       mode;
    logic             scroll_en;
    logic [DIV_W-1:0] speed;
    logic [15:0]      color;
    logic             frame_tick;
    logic             x_edge;
    logic             y_edge;

    modport master (
        output x, y, mode, scroll_en, speed,
        input  color, frame_tick, x_edge, y_edge
    );

    modport slave (
        input  x, y, mode, scroll_en, speed,
        output color, frame_tick, x_edge, y_edge
    );
endinterface

// File: rtl/lcd_frame_ctl.sv
// Frame-start detection, per-frame mode latch and scroll divider/offset.
// Latency: frame_tick one cycle after registered (0,0). Backpressure: none.
module lcd_frame_ctl
    import lcd_pkg::*;
#(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [X_W-1:0]   x_q,
    input  logic [Y_W-1:0]   y_q,
    input  pat_mode_t        mode_in,
    input  logic             scroll_en,
    input  logic [DIV_W-1:0] speed,
    output logic             frame_tick,
    output pat_mode_t        mode_eff,
    output logic [X_W-1:0]   offset_eff
);
    localparam logic [X_W-1:0]   ONE_X = X_W'(1);
    localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);

    logic             zero_now;
    logic             zero_prev;
    logic             start;
    pat_mode_t        mode_q;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [X_W-1:0]   offset_q;
    logic [X_W-1:0]   offset_nxt;

    assign zero_now = (x_q == '0) && (y_q == '0);
    assign start    = zero_now && !zero_prev;

    // A speed lowered below div_cnt lets the counter run through the wrap and match later.
    always_comb begin
        div_nxt    = div_cnt;
        offset_nxt = offset_q;
        if (start) begin
            if (div_cnt == speed) begin
                div_nxt = '0;
                if (scroll_en) begin
                    offset_nxt = offset_q + ONE_X;
                end
            end else begin
                div_nxt = div_cnt + ONE_D;
            end
        end
    end

    // Pixel (0,0) is coloured on the same edge that updates mode/offset, so forward the new values.
    assign mode_eff   = start ? mode_in : mode_q;
    assign offset_eff = offset_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_prev  <= 1'b0;
            frame_tick <= 1'b0;
            mode_q     <= PAT_SOLID;
            div_cnt    <= '0;
            offset_q   <= '0;
        end else begin
            zero_prev  <= zero_now;
            frame_tick <= start;
            if (start) begin
                mode_q <= mode_in;
            end
            div_cnt    <= div_nxt;
            offset_q   <= offset_nxt;
        end
    end

endmodule

// File: rtl/lcd_pattern_gen.sv
// Test-pattern generator: maps driver x/y to an RGB565 colour in one of four modes, with scroll.
// Latency: 2 cycles x/y -> color/edges. Backpressure: none, the driver holds each pixel.
module lcd_pattern_gen
    import lcd_pkg::*;
#(
    parameter int      X_W       = 8,
    parameter int      Y_W       = 7,
    parameter int      H_PIX     = 160,
    parameter int      V_PIX     = 80,
    parameter int      CELL_LOG2 = 3,
    parameter int      DIV_W     = 4,
    parameter rgb565_t COLOR_A   = 16'h07E0,
    parameter rgb565_t COLOR_B   = 16'hF81F
) (
    input  logic             clk,
    input  logic             rst_n,
    lcd_pattern_gen_if.slave bus
);
    localparam logic [X_W:0]   H_LIM  = (X_W+1)'(H_PIX);
    localparam logic [Y_W:0]   V_LIM  = (Y_W+1)'(V_PIX);
    localparam logic [X_W-1:0] H_LAST = X_W'(H_PIX - 1);
    localparam logic [Y_W-1:0] V_LAST = Y_W'(V_PIX - 1);

    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    pat_mode_t      mode_eff;
    logic [X_W-1:0] offset_eff;
    logic [X_W-1:0] xs;
    logic [5:0]     g6;
    logic           in_view;
    rgb565_t        color_d;

    // All-ones reset makes the first (0,0) after reset look like a fresh frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '1;
            y_q <= '1;
        end else begin
            x_q <= bus.x;
            y_q <= bus.y;
        end
    end

    lcd_frame_ctl #(
        .X_W   (X_W),
        .Y_W   (Y_W),
        .DIV_W (DIV_W)
    ) u_frame_ctl (
        .clk        (clk),
        .rst_n      (rst_n),
        .x_q        (x_q),
        .y_q        (y_q),
        .mode_in    (pat_mode_t'(bus.mode)),
        .scroll_en  (bus.scroll_en),
        .speed      (bus.speed),
        .frame_tick (bus.frame_tick),
        .mode_eff   (mode_eff),
        .offset_eff (offset_eff)
    );

    assign xs      = x_q + offset_eff;
    assign in_view = ({1'b0, x_q} < H_LIM) && ({1'b0, y_q} < V_LIM);

    generate
        if (Y_W >= 6) begin : g_grad_wide
            assign g6 = y_q[Y_W-1:Y_W-6];
        end else begin : g_grad_narrow
            assign g6 = {{(6-Y_W){1'b0}}, y_q};
        end
    endgenerate

    always_comb begin
        color_d = RGB_BLACK;
        if (in_view) begin
            case (mode_eff)
                PAT_SOLID: color_d = COLOR_A;
                PAT_CHECK: color_d = (xs[CELL_LOG2] ^ y_q[CELL_LOG2]) ? COLOR_A : COLOR_B;
                PAT_BARS:  color_d = bar_color(xs[X_W-1:X_W-3]);
                PAT_GRAD:  color_d = {xs[X_W-1:X_W-5], g6, 5'b00000};
                default:   color_d = RGB_BLACK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.color  <= RGB_BLACK;
            bus.x_edge <= 1'b0;
            bus.y_edge <= 1'b0;
        end else begin
            bus.color  <= color_d;
            bus.x_edge <= (x_q == H_LAST);
            bus.y_edge <= (y_q == V_LAST);
        end
    end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Bench for lcd_pattern_gen: frame-level reference model compared every cycle, plus pinned pixels.
module tb_lcd_pattern_gen;

    logic clk = 1'b0;
    logic rst_n;

    lcd_pattern_gen_if #(.X_W(8), .Y_W(7), .DIV_W(4)) bus ();

    lcd_pattern_gen #(
        .X_W(8), .Y_W(7), .H_PIX(160), .V_PIX(80), .CELL_LOG2(3), .DIV_W(4),
        .COLOR_A(16'h07E0), .COLOR_B(16'hF81F)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ticks = 0;

    // Reference colour of one pixel given the active mode and scroll offset.
    function automatic logic [15:0] ref_pix(input int md, input int px, input int py, input int off);
        int xs;
        int b;
        logic [15:0] r;
        xs = (px + off) % 256;
        b  = xs / 32;
        r  = 16'h0000;
        if (px < 160 && py < 80) begin
            case (md)
                0: r = 16'h07E0;
                1: r = ((((xs / 8) % 2) ^ ((py / 8) % 2)) != 0) ? 16'h07E0 : 16'hF81F;
                2: r = {((b & 4) != 0) ? 5'h1F : 5'h00,
                        ((b & 2) != 0) ? 6'h3F : 6'h00,
                        ((b & 1) != 0) ? 5'h1F : 5'h00};
                default: r = 16'((xs / 8) * 2048 + (py / 2) * 32);
            endcase
        end
        return r;
    endfunction

    // Model state: last registered pixel, previous one, active mode, divider and offset.
    int m_xq, m_yq, m_mode, m_div, m_off;
    bit m_pz, m_start;
    logic [15:0] e_col;
    bit e_tick, e_xe, e_ye;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_xq = 255; m_yq = 127; m_pz = 0;
            m_mode = 0; m_div = 0; m_off = 0;
            e_col = 16'h0000; e_tick = 0; e_xe = 0; e_ye = 0;
        end else begin
            m_start = (m_xq == 0) && (m_yq == 0) && !m_pz;
            if (m_start) begin
                m_mode = int'(bus.mode);
                if (m_div == int'(bus.speed)) begin
                    m_div = 0;
                    if (bus.scroll_en) m_off = (m_off + 1) % 256;
                end else begin
                    m_div = (m_div + 1) % 16;
                end
            end
            e_tick = m_start;
            e_col  = ref_pix(m_mode, m_xq, m_yq, m_off);
            e_xe   = (m_xq == 159);
            e_ye   = (m_yq == 79);
            m_pz   = (m_xq == 0) && (m_yq == 0);
            m_xq   = int'(bus.x);
            m_yq   = int'(bus.y);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            n_tests++;
            if (bus.color !== e_col || bus.frame_tick !== e_tick ||
                bus.x_edge !== e_xe || bus.y_edge !== e_ye) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t got color=%h tick=%b xe=%b ye=%b want color=%h tick=%b xe=%b ye=%b",
                         $time, bus.color, bus.frame_tick, bus.x_edge, bus.y_edge,
                         e_col, e_tick, e_xe, e_ye);
            end
            if (bus.frame_tick === 1'b1) n_ticks++;
        end
    end

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Present one pixel and hold it for n clock cycles, ending just after a falling edge.
    task automatic px(input int xx, input int yy, input int n);
        bus.x = 8'(xx);
        bus.y = 7'(yy);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    int t0;
    int guard;

    initial begin
        rst_n = 1'b0;
        bus.x = 8'd5; bus.y = 7'd5;
        bus.mode = 2'd1; bus.scroll_en = 1'b0; bus.speed = 4'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_color", bus.color, 16'h0000);
        chk("reset_tick", 16'(bus.frame_tick), 16'h0000);
        chk("reset_xedge", 16'(bus.x_edge), 16'h0000);
        chk("reset_yedge", 16'(bus.y_edge), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Full-frame sweep, checker mode, no scroll.
        t0 = n_ticks;
        for (int yy = 0; yy < 80; yy++)
            for (int xx = 0; xx < 160; xx++)
                px(xx, yy, 1);
        px(159, 79, 3);
        chk("sweep_one_tick", 16'(n_ticks - t0), 16'd1);

        px(0, 0, 3);   chk("chk_0_0", bus.color, 16'hF81F);
        px(8, 0, 3);   chk("chk_8_0", bus.color, 16'h07E0);
        px(8, 8, 3);   chk("chk_8_8", bus.color, 16'hF81F);

        bus.mode = 2'd2;
        px(50, 50, 2); px(0, 0, 3);
        px(0, 5, 3);   chk("bars_x0", bus.color, 16'h0000);
        px(20, 5, 3);  chk("bars_x20", bus.color, 16'h0000);
        px(32, 5, 3);  chk("bars_x32", bus.color, 16'h001F);
        px(96, 5, 3);  chk("bars_x96", bus.color, 16'h07FF);
        px(159, 5, 3); chk("bars_x159", bus.color, 16'hF800);
        chk("x_edge_159", 16'(bus.x_edge), 16'd1);

        bus.mode = 2'd1;
        px(1, 1, 2); px(0, 0, 3);
        px(8, 39, 3);
        bus.mode = 2'd0;
        px(8, 40, 3);  chk("midframe_mode_held", bus.color, 16'hF81F);
        px(3, 79, 2); px(0, 0, 3);
        px(8, 40, 3);  chk("next_frame_solid", bus.color, 16'h07E0);

        bus.mode = 2'd3;
        px(1, 1, 2); px(0, 0, 3);
        px(100, 50, 3); chk("grad_100_50", bus.color, 16'h6320);
        px(170, 5, 3);  chk("oob_x170", bus.color, 16'h0000);
        px(5, 90, 3);   chk("oob_y90", bus.color, 16'h0000);
        px(20, 79, 3);  chk("grad_20_79", bus.color, 16'h14E0);
        chk("y_edge_79", 16'(bus.y_edge), 16'd1);

        // Random pixels, frame starts and control changes, checked by the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) bus.scroll_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) bus.speed = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) px(0, 0, $urandom_range(1, 3));
            else px($urandom_range(0, 175), $urandom_range(0, 90), $urandom_range(1, 3));
        end

        // Scrolling: every third frame steps the offset.
        bus.mode = 2'd1; bus.scroll_en = 1'b1; bus.speed = 4'd2;
        px(60, 3, 1);
        pulse_reset();
        t0 = n_ticks;
        for (int f = 0; f < 9; f++) begin
            px(0, 0, 3);
            px(5, 0, 3);
            if (f == 8) chk("scroll_x5", bus.color, 16'h07E0);
            px(4, 0, 3);
            if (f == 8) chk("scroll_x4", bus.color, 16'hF81F);
        end
        chk("scroll_ticks", 16'(n_ticks - t0), 16'd9);
        chk("scroll_offset3", 16'(m_off), 16'd3);

        guard = 0;
        while (m_off != 5 && guard < 30) begin
            px(0, 0, 3); px(60, 3, 2);
            guard++;
        end
        chk("reach_offset5", 16'(m_off), 16'd5);
        px(159, 79, 3);
        chk("pre_reset_color", bus.color, 16'h07E0);

        // Asynchronous mid-frame reset.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_color", bus.color, 16'h0000);
        chk("async_rst_xedge", 16'(bus.x_edge), 16'h0000);
        chk("async_rst_yedge", 16'(bus.y_edge), 16'h0000);
        chk("async_rst_tick", 16'(bus.frame_tick), 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        px(7, 7, 2);
        t0 = n_ticks;
        px(0, 0, 3);
        chk("post_rst_tick", 16'(n_ticks - t0), 16'd1);
        px(5, 0, 3);
        chk("post_rst_offset0", bus.color, 16'hF81F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
